iob_axi_master_bridge: RTL and testbench
========================================

Name: iob_axi_master_bridge

Overview:
- Converts single-word native memory requests (valid/addr/wdata/wstrb → ready/rdata) from the CPU/accelerator side into AXI4 single-beat master transactions.
- Sits directly upstream of axi_ram (or the interconnect feeding it) and drives its s_axi_* slave port.
- One transaction outstanding at a time.
- Response errors are reported on a sticky-free per-transaction error flag.

Parameters:
- ADDR_WIDTH, 16, AXI and native address width in bits.
- DATA_WIDTH, 32, data bus width in bits; multiple of 8, power-of-two bytes.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant ID driven on awid/arid.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- valid  in  1  native request strobe
- addr  in  ADDR_WIDTH  byte address
- wdata  in  DATA_WIDTH  write data
- wstrb  in  STRB_WIDTH  byte enables; nonzero = write, zero = read
- rdata  out  DATA_WIDTH  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- error  out  1  valid while ready=1; 1 = non-OKAY response or protocol fault
- busy  out  1  transaction in flight (state != IDLE)
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}  out / m_axi_awready in — AXI4 write address channel
- m_axi_w{data,strb,last,valid}  out / m_axi_wready in — AXI4 write data channel
- m_axi_b{id,resp,valid}  in / m_axi_bready out — AXI4 write response channel
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out / m_axi_arready in — AXI4 read address channel
- m_axi_r{id,data,resp,last,valid}  in / m_axi_rready out — AXI4 read data channel
- Widths per AXI4: len 8, size 3, burst 2, lock 1, cache 4, prot 3, resp 2.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All valid/ready outputs = 0: awvalid, wvalid, bready, arvalid, rready, ready, error, busy.
  - rdata = 0.
  - Any AXI transaction in flight is abandoned; the system resets the slave together with this block.
- Constant AXI fields:
  - awid = arid = AXI_ID.
  - len = 0.
  - size = log2(STRB_WIDTH).
  - burst = INCR (01).
  - lock = 0, cache = 0011, prot = 000.
  - wlast = 1.
  - Address forwarded unmodified; unaligned addresses are the slave's concern.
- All AXI valid/ready outputs are registered; no combinational path from any AXI input to any AXI output.
- States: IDLE, WRITE, WRESP, RADDR, RDATA.
- IDLE:
  - Request accepted when valid=1 and ready=0 (ready=0 blocks re-acceptance of a held request in its completion cycle).
  - On accept: latch addr, wdata, wstrb.
  - wstrb≠0 → WRITE with awvalid=1 and wvalid=1 from the next cycle.
  - wstrb=0 → RADDR with arvalid=1 from the next cycle.
- Request signals are sampled only at accept. valid asserted while busy=1 is ignored; no queuing.
- WRITE:
  - awvalid drops the cycle after its awready handshake; wvalid drops the cycle after its wready handshake. The two are independent and may complete in either order or in the same cycle.
  - awaddr/wdata/wstrb stay stable while the corresponding valid is high.
  - When both have handshaken → WRESP, bready=1.
- WRESP:
  - On bvalid&bready: bready=0, state=IDLE.
  - ready=1 for exactly the next cycle.
  - error = (bresp≠00) | (bid≠AXI_ID).
- RADDR: on arvalid&arready → RDATA, arvalid=0, rready=1.
- RDATA:
  - On rvalid&rready: capture rdata, rready=0, state=IDLE.
  - ready=1 next cycle.
  - error = (rresp≠00) | (rlast=0) | (rid≠AXI_ID).
- rdata holds its value until the next read completes; it is unchanged by writes.
- Latency, zero-wait slave responding one cycle after address/data handshake: accept at cycle 0, ready at cycle 3 for both reads and writes.
- Back-to-back: the next request can be accepted the cycle after the ready pulse, so the minimum period is 4 cycles.
- Slave stalls (awready/wready/arready/bvalid/rvalid held low) hold state indefinitely; there is no timeout.
- busy=1 from the cycle after accept through the ready cycle exclusive. busy=0 in the ready cycle.

Test Plan:
- Write, zero-wait slave: valid, addr=0x0010, wdata=0xDEADBEEF, wstrb=0xF at cycle 0 → awvalid and wvalid =1 at cycle 1 with awaddr=0x0010, wlast=1, len=0, size=2; ready=1, error=0 at cycle 3; axi_ram word 4 = 0xDEADBEEF.
- Read back through axi_ram: wstrb=0, addr=0x0010 → arvalid with araddr=0x0010; ready=1 with rdata=0xDEADBEEF, error=0; ready high exactly one cycle.
- Split write handshake: awready held low 5 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held with stable awaddr until awready; bready asserts only after both handshakes; a single ready pulse.
- Error responses: bresp=10 → ready with error=1. rresp=00 with rlast=0 → error=1. Following OKAY transaction → error=0.
- Held valid and ignored requests: valid kept high across completion with a new addr presented after ready → exactly one acceptance per ready pulse; a second valid asserted while busy=1 with different addr → not issued until IDLE.
- Async reset mid-read: assert rst between arvalid and rvalid → all outputs 0 immediately, without waiting for a clock edge; after release, a write of 0x12345678 to 0x0020 completes normally.

Source files
------------

// File: rtl/iob_axi_master_bridge_if.sv
// AXI4 bus between a single-beat master bridge and its slave.
// Carries the write address, write data, write response, read address and read data channels.
interface iob_axi_master_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/iob_axi_master_bridge.sv
// Native single-word request -> AXI4 single-beat master, one transaction outstanding.
// Zero-wait slave: accept at cycle 0, ready pulse at cycle 3; AXI stalls hold the FSM indefinitely.
module iob_axi_master_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  error,
  output logic                  busy,
  iob_axi_master_bridge_if.master m_axi
);

  localparam logic [ID_WIDTH-1:0] ID_C   = ID_WIDTH'(AXI_ID);
  localparam logic [2:0]          SIZE_C = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_done, w_done;
  logic                  awvalid_c, wvalid_c, bready_c, arvalid_c, rready_c;
  logic                  accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // ready gates acceptance so a request held across its completion is not taken twice
  assign accept = (state == IDLE) && valid && !ready;
  assign aw_hs  = awvalid_c && m_axi.awready;
  assign w_hs   = wvalid_c  && m_axi.wready;
  assign b_hs   = bready_c  && m_axi.bvalid;
  assign ar_hs  = arvalid_c && m_axi.arready;
  assign r_hs   = rready_c  && m_axi.rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (wstrb != '0) ? WRITE : RADDR;
      WRITE: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WRESP;
      WRESP: if (b_hs) state_nxt = IDLE;
      RADDR: if (ar_hs) state_nxt = RDATA;
      RDATA: if (r_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Channel strobes decode only flops, so no AXI input reaches an AXI output combinationally
  always_comb begin
    awvalid_c = 1'b0;
    wvalid_c  = 1'b0;
    bready_c  = 1'b0;
    arvalid_c = 1'b0;
    rready_c  = 1'b0;
    case (state)
      WRITE: begin
        awvalid_c = !aw_done;
        wvalid_c  = !w_done;
      end
      WRESP:   bready_c  = 1'b1;
      RADDR:   arvalid_c = 1'b1;
      RDATA:   rready_c  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ready   <= 1'b0;
      error   <= 1'b0;
      rdata   <= '0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == WRITE) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done  || w_hs;
      end
      if (b_hs) begin
        ready <= 1'b1;
        error <= (m_axi.bresp != 2'b00) || (m_axi.bid != ID_C);
      end
      if (r_hs) begin
        ready <= 1'b1;
        error <= (m_axi.rresp != 2'b00) || !m_axi.rlast || (m_axi.rid != ID_C);
        rdata <= m_axi.rdata;
      end
    end
  end

  assign busy = (state != IDLE);

  assign m_axi.awid    = ID_C;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = SIZE_C;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_c;

  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wvalid  = wvalid_c;

  assign m_axi.bready  = bready_c;

  assign m_axi.arid    = ID_C;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = SIZE_C;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_c;

  assign m_axi.rready  = rready_c;

endmodule

// File: tb/tb_iob_axi_master_bridge.sv
// Directed bench for iob_axi_master_bridge with a small AXI RAM model and a completion scoreboard.
module tb_iob_axi_master_bridge;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [DW-1:0] rdata;
  logic          ready, error, busy;

  always #5 clk = ~clk;

  iob_axi_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m_axi ();

  iob_axi_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ID_WIDTH(IW), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .error(error), .busy(busy), .m_axi(m_axi)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- AXI RAM model ----------------
  logic [DW-1:0] mem [0:63];
  logic [1:0]    bresp_cfg, rresp_cfg;
  logic [IW-1:0] bid_cfg;
  logic          rlast_cfg;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  logic [SW-1:0] w_s;
  logic          s_aw_hs, s_w_hs;
  logic [AW-1:0] s_wa;
  logic [DW-1:0] s_wd, s_merged;
  logic [SW-1:0] s_ws;

  assign s_aw_hs = m_axi.awvalid & m_axi.awready;
  assign s_w_hs  = m_axi.wvalid & m_axi.wready;
  assign s_wa    = s_aw_hs ? m_axi.awaddr : aw_a;
  assign s_wd    = s_w_hs ? m_axi.wdata : w_d;
  assign s_ws    = s_w_hs ? m_axi.wstrb : w_s;

  always_comb begin
    s_merged = mem[s_wa[7:2]];
    for (int b = 0; b < SW; b++)
      if (s_ws[b]) s_merged[8*b +: 8] = s_wd[8*b +: 8];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      m_axi.bvalid <= 1'b0;
      m_axi.bresp  <= 2'b00;
      m_axi.bid    <= '0;
      m_axi.rvalid <= 1'b0;
      m_axi.rdata  <= '0;
      m_axi.rresp  <= 2'b00;
      m_axi.rlast  <= 1'b0;
      m_axi.rid    <= '0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_a   <= '0;
      w_d    <= '0;
      w_s    <= '0;
    end else begin
      if (s_aw_hs) aw_a <= m_axi.awaddr;
      if (s_w_hs) begin
        w_d <= m_axi.wdata;
        w_s <= m_axi.wstrb;
      end
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        mem[s_wa[7:2]] <= s_merged;
        m_axi.bvalid   <= 1'b1;
        m_axi.bresp    <= bresp_cfg;
        m_axi.bid      <= bid_cfg;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_got || s_aw_hs;
        w_got  <= w_got || s_w_hs;
        if (m_axi.bvalid && m_axi.bready) m_axi.bvalid <= 1'b0;
      end
      if (m_axi.arvalid && m_axi.arready) begin
        m_axi.rvalid <= 1'b1;
        m_axi.rdata  <= mem[m_axi.araddr[7:2]];
        m_axi.rresp  <= rresp_cfg;
        m_axi.rlast  <= rlast_cfg;
        m_axi.rid    <= '0;
      end else if (m_axi.rvalid && m_axi.rready) begin
        m_axi.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          is_rd;
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t    sb[$];
  exp_t    mon_e;
  int      done_cnt = 0;
  logic    prev_ready = 1'b0;
  logic [DW-1:0] model_rdata;

  always @(negedge clk) begin
    if (rst) begin
      prev_ready <= 1'b0;
    end else begin
      if (ready) begin
        chk("ready_width", prev_ready, 1'b0);
        chk("busy_in_ready", busy, 1'b0);
        chk("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk(mon_e.is_rd ? "rd_rdata" : "wr_rdata_hold", rdata, mon_e.rd);
          chk(mon_e.is_rd ? "rd_error" : "wr_error", error, mon_e.err);
        end
        done_cnt <= done_cnt + 1;
      end
      prev_ready <= ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [DW-1:0] exp_rd,
                           input logic exp_err);
    addr  = a;
    wdata = d;
    wstrb = s;
    valid = 1'b1;
    if (s == '0) model_rdata = exp_rd;
    sb.push_back('{is_rd: (s == '0), rd: model_rdata, err: exp_err});
  endtask

  task automatic wait_done(input int n0, input int budget, input string tag);
    int c = 0;
    while (done_cnt == n0 && c < budget) begin
      step();
      c++;
    end
    chk({tag, "_done"}, done_cnt - n0, 1);
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [DW-1:0] exp_rd,
                        input logic exp_err, input string tag);
    int n0;
    step();
    n0 = done_cnt;
    start_req(a, d, s, exp_rd, exp_err);
    step();
    valid = 1'b0;
    wait_done(n0, 20, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    m_axi.awready = 1'b1; m_axi.wready = 1'b1; m_axi.arready = 1'b1;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; bid_cfg = '0; rlast_cfg = 1'b1;
    model_rdata = '0;

    // reset state
    rst = 1'b1;
    step(); step();
    chk("rst_awvalid", m_axi.awvalid, 1'b0);
    chk("rst_wvalid", m_axi.wvalid, 1'b0);
    chk("rst_bready", m_axi.bready, 1'b0);
    chk("rst_arvalid", m_axi.arvalid, 1'b0);
    chk("rst_rready", m_axi.rready, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    step();

    // zero-wait write with cycle-exact checks
    start_req(16'h0010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    step();
    valid = 1'b0;
    chk("wr_c1_awvalid", m_axi.awvalid, 1'b1);
    chk("wr_c1_wvalid", m_axi.wvalid, 1'b1);
    chk("wr_c1_awaddr", m_axi.awaddr, 16'h0010);
    chk("wr_c1_wlast", m_axi.wlast, 1'b1);
    chk("wr_c1_awlen", m_axi.awlen, 8'd0);
    chk("wr_c1_awsize", m_axi.awsize, 3'd2);
    chk("wr_c1_awburst", m_axi.awburst, 2'b01);
    chk("wr_c1_awcache", m_axi.awcache, 4'b0011);
    chk("wr_c1_wdata", m_axi.wdata, 32'hDEADBEEF);
    chk("wr_c1_busy", busy, 1'b1);
    step();
    chk("wr_c2_bready", m_axi.bready, 1'b1);
    chk("wr_c2_awvalid", m_axi.awvalid, 1'b0);
    step();
    chk("wr_c3_ready", ready, 1'b1);
    chk("wr_mem4", mem[4], 32'hDEADBEEF);

    // read back with cycle-exact checks
    step();
    start_req(16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    step();
    valid = 1'b0;
    chk("rd_c1_arvalid", m_axi.arvalid, 1'b1);
    chk("rd_c1_araddr", m_axi.araddr, 16'h0010);
    chk("rd_c1_arsize", m_axi.arsize, 3'd2);
    chk("rd_c1_awvalid", m_axi.awvalid, 1'b0);
    step();
    chk("rd_c2_rready", m_axi.rready, 1'b1);
    chk("rd_c2_arvalid", m_axi.arvalid, 1'b0);
    step();
    chk("rd_c3_ready", ready, 1'b1);
    chk("rd_c3_rdata", rdata, 32'hDEADBEEF);
    step();
    chk("rd_c4_ready_low", ready, 1'b0);

    // split write handshake: awready stalled, wready immediate
    m_axi.awready = 1'b0;
    n0 = done_cnt;
    start_req(16'h0014, 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0);
    step();
    valid = 1'b0;
    chk("split_c1_wvalid", m_axi.wvalid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("split_wvalid_dropped", m_axi.wvalid, 1'b0);
      chk("split_awvalid_held", m_axi.awvalid, 1'b1);
      chk("split_awaddr_stable", m_axi.awaddr, 16'h0014);
      chk("split_no_bready", m_axi.bready, 1'b0);
    end
    m_axi.awready = 1'b1;
    wait_done(n0, 20, "split");
    step(); step(); step();
    chk("split_single_ready", done_cnt - n0, 1);
    chk("split_mem5", mem[5], 32'hA5A5_0F0F);

    // error responses, then recovery
    bresp_cfg = 2'b10;
    do_req(16'h0018, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, "bresp_err");
    bresp_cfg = 2'b00;
    rlast_cfg = 1'b0;
    do_req(16'h0014, 32'h0, 4'h0, 32'hA5A5_0F0F, 1'b1, "rlast_err");
    rlast_cfg = 1'b1;
    bid_cfg = 8'h01;
    do_req(16'h001C, 32'h0000_0077, 4'h1, 32'h0, 1'b1, "bid_err");
    bid_cfg = '0;
    do_req(16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "okay_after_err");
    do_req(16'h001C, 32'h0, 4'h0, 32'h1000_0077, 1'b0, "strb_read");

    // held valid: one acceptance per ready pulse
    step();
    n0 = done_cnt;
    start_req(16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    wait_done(n0, 20, "held1");
    step();
    n0 = done_cnt;
    start_req(16'h0014, 32'h0, 4'h0, 32'hA5A5_0F0F, 1'b0);
    wait_done(n0, 20, "held2");
    valid = 1'b0;
    n0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_no_reaccept", busy, 1'b0);
    end
    chk("held_no_extra_ready", done_cnt - n0, 0);

    // request presented while busy is ignored until IDLE
    step();
    m_axi.awready = 1'b0;
    n0 = done_cnt;
    start_req(16'h0018, 32'h1111_2222, 4'hF, 32'h0, 1'b0);
    step();
    addr  = 16'h001C;
    wstrb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_ignore_arvalid", m_axi.arvalid, 1'b0);
      chk("busy_ignore_awaddr", m_axi.awaddr, 16'h0018);
    end
    m_axi.awready = 1'b1;
    wait_done(n0, 20, "busy_wr");
    n0 = done_cnt;
    start_req(16'h001C, 32'h0, 4'h0, 32'h1000_0077, 1'b0);
    step();
    step();
    valid = 1'b0;
    chk("late_arvalid", m_axi.arvalid, 1'b1);
    chk("late_araddr", m_axi.araddr, 16'h001C);
    wait_done(n0, 20, "late_rd");
    chk("busy_wr_mem6", mem[6], 32'h1111_2222);

    // asynchronous reset between arvalid and rvalid
    step();
    m_axi.arready = 1'b0;
    addr = 16'h0010; wstrb = 4'h0; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    chk("arst_pre_arvalid", m_axi.arvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_arvalid", m_axi.arvalid, 1'b0);
    chk("arst_rready", m_axi.rready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", ready, 1'b0);
    chk("arst_error", error, 1'b0);
    chk("arst_rdata", rdata, 32'h0);
    model_rdata = '0;
    m_axi.arready = 1'b1;
    step(); step();
    rst = 1'b0;
    do_req(16'h0020, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "post_rst_wr");
    do_req(16'h0020, 32'h0, 4'h0, 32'h1234_5678, 1'b0, "post_rst_rd");

    step(); step();
    chk("sb_empty_at_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
